// File: rtl/frame_scanout.sv
// frame_scanout: raster timing generator and sequential 1-bpp framebuffer reader.
// Emits pixel/de/hsync/vsync two ce edges after the counters and a one-clk swap pulse per frame.
module frame_scanout #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int HOR_FRONT_PORCH   = 16,
   parameter int HOR_SYNC_PULSE    = 96,
   parameter int HOR_BACK_PORCH    = 48,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int VER_FRONT_PORCH   = 10,
   parameter int VER_SYNC_PULSE    = 2,
   parameter int VER_BACK_PORCH    = 33,
   localparam int RD_ADDR_WIDTH    = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   output logic                     rd_en,
   output logic [RD_ADDR_WIDTH-1:0] rd_addr,
   input  logic                     rd_data,
   output logic                     swap,
   output logic                     pixel,
   output logic                     de,
   output logic                     hsync,
   output logic                     vsync
);
   localparam int HT = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
   localparam int VT = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
   localparam int XW = $clog2(HT);
   localparam int YW = $clog2(VT);
   localparam logic [XW-1:0] X_LAST  = XW'(HT - 1);
   localparam logic [XW-1:0] X_ACT   = XW'(HOR_ACTIVE_PIXELS);
   localparam logic [XW-1:0] X_APIX  = XW'(HOR_ACTIVE_PIXELS - 1);
   localparam logic [XW-1:0] X_HS0   = XW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
   localparam logic [XW-1:0] X_HS1   = XW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(VT - 1);
   localparam logic [YW-1:0] Y_ACT   = YW'(VER_ACTIVE_PIXELS);
   localparam logic [YW-1:0] Y_APIX  = YW'(VER_ACTIVE_PIXELS - 1);
   localparam logic [YW-1:0] Y_VS0   = YW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
   localparam logic [YW-1:0] Y_VS1   = YW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE - 1);

   logic [XW-1:0]            x_q, x_d;
   logic [YW-1:0]            y_q, y_d;
   logic [RD_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                     rd_pending_q, rd_pending_d;
   logic                     pix_hold_q, pix_hold_d;
   logic                     d1_active_q, d1_active_d;
   logic                     d1_hs_q, d1_hs_d;
   logic                     d1_vs_q, d1_vs_d;
   logic                     de_q, de_d;
   logic                     hsync_q, hsync_d;
   logic                     vsync_q, vsync_d;
   logic                     pixel_q, pixel_d;
   logic                     swap_q, swap_d;
   logic                     active, last_pix, hs, vs, pix_sel;

   assign active   = (x_q < X_ACT) && (y_q < Y_ACT);
   assign last_pix = (x_q == X_APIX) && (y_q == Y_APIX);
   assign hs       = (x_q >= X_HS0) && (x_q <= X_HS1);
   assign vs       = (y_q >= Y_VS0) && (y_q <= Y_VS1);
   // Fresh read data when this clk follows a read, otherwise the value latched during a ce gap
   assign pix_sel  = rd_pending_q ? rd_data : pix_hold_q;
   assign rd_en    = ce & active;
   assign rd_addr  = addr_q;
   assign swap     = swap_q;
   assign pixel    = pixel_q;
   assign de       = de_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;

   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      addr_d       = addr_q;
      d1_active_d  = d1_active_q;
      d1_hs_d      = d1_hs_q;
      d1_vs_d      = d1_vs_q;
      de_d         = de_q;
      hsync_d      = hsync_q;
      vsync_d      = vsync_q;
      pixel_d      = pixel_q;
      rd_pending_d = rd_en;
      pix_hold_d   = rd_pending_q ? rd_data : pix_hold_q;
      swap_d       = ce & last_pix;
      if (ce) begin
         x_d         = (x_q == X_LAST) ? '0 : x_q + 1'b1;
         y_d         = (x_q != X_LAST) ? y_q : ((y_q == Y_LAST) ? '0 : y_q + 1'b1);
         addr_d      = !active ? addr_q : (last_pix ? '0 : addr_q + 1'b1);
         d1_active_d = active;
         d1_hs_d     = hs;
         d1_vs_d     = vs;
         de_d        = d1_active_q;
         hsync_d     = ~d1_hs_q;
         vsync_d     = ~d1_vs_q;
         pixel_d     = d1_active_q & pix_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         rd_pending_q <= 1'b0;
         pix_hold_q   <= 1'b0;
         d1_active_q  <= 1'b0;
         d1_hs_q      <= 1'b0;
         d1_vs_q      <= 1'b0;
         de_q         <= 1'b0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         pixel_q      <= 1'b0;
         swap_q       <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         rd_pending_q <= rd_pending_d;
         pix_hold_q   <= pix_hold_d;
         d1_active_q  <= d1_active_d;
         d1_hs_q      <= d1_hs_d;
         d1_vs_q      <= d1_vs_d;
         de_q         <= de_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         pixel_q      <= pixel_d;
         swap_q       <= swap_d;
      end
   end
endmodule
